// File: rtl/dbg_run_ctrl.sv
// dbg_run_ctrl: run control (halt/resume/step/breakpoint) gating the core clock enable
module dbg_run_ctrl #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STEP_W        = 8,
  parameter int unsigned XLEN          = 32,
  parameter bit          HALT_ON_RESET = 1'b0
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              cmd_toggle,
  input  logic [1:0]        cmd,
  input  logic [STEP_W-1:0] step_count,
  output logic              cmd_ack_toggle,
  input  logic              bp_en,
  input  logic [XLEN-1:0]   bp_addr,
  input  logic [XLEN-1:0]   pc,
  output logic              dbg_clk_en,
  output logic              halted,
  output logic              bp_hit,
  output logic [31:0]       cycle_count
);
  typedef enum logic [1:0] {S_RUN, S_HALTED, S_STEP} state_t;
  localparam logic [1:0] CMD_HALT   = 2'b01;
  localparam logic [1:0] CMD_RESUME = 2'b10;
  localparam logic [1:0] CMD_STEP   = 2'b11;
  localparam state_t RST_STATE = HALT_ON_RESET ? S_HALTED : S_RUN;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;
  logic                   r_pend;
  logic [1:0]             r_cmd;
  logic [STEP_W-1:0]      r_step_n;
  state_t                 r_state;
  logic [STEP_W-1:0]      r_rem;
  logic                   r_bp_mask;
  logic                   r_bp_hit;
  logic                   r_dbg_clk_en;
  logic                   r_halted;
  logic                   r_ack;
  logic [31:0]            r_cycle_count;
  logic                   w_det;
  logic                   w_match;
  logic                   w_halt;
  logic                   w_resume;
  logic                   w_step;
  state_t                 w_nstate;
  logic [STEP_W-1:0]      w_nrem;
  logic                   w_nbp_hit;
  assign w_det    = r_sync[SYNC_STAGES-1] ^ r_last;
  assign w_match  = bp_en && (pc == bp_addr) && !r_bp_mask && (r_state != S_HALTED);
  assign w_halt   = r_pend && (r_cmd == CMD_HALT);
  assign w_resume = r_pend && (r_cmd == CMD_RESUME);
  assign w_step   = r_pend && (r_cmd == CMD_STEP);
  // bring the tck-domain toggle into sysclk
  always_ff @(posedge sysclk or posedge reset)
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], cmd_toggle};
  // latch the command and its step length on each toggle edge
  always_ff @(posedge sysclk or posedge reset)
    if (reset) begin
      r_last   <= 1'b0;
      r_pend   <= 1'b0;
      r_cmd    <= '0;
      r_step_n <= '0;
    end else begin
      r_pend <= w_det;
      if (w_det) begin
        r_last   <= r_sync[SYNC_STAGES-1];
        r_cmd    <= cmd;
        r_step_n <= step_count;
      end
    end
  // next state: a breakpoint outranks any command arriving in the same cycle
  always_comb begin
    w_nstate  = r_state;
    w_nrem    = r_rem;
    w_nbp_hit = r_bp_hit;
    if (w_match) begin
      w_nstate  = S_HALTED;
      w_nbp_hit = 1'b1;
    end else if (r_state == S_HALTED) begin
      if (w_resume) begin
        w_nstate  = S_RUN;
        w_nbp_hit = 1'b0;
      end else if (w_step && (r_step_n != '0)) begin
        w_nstate  = S_STEP;
        w_nrem    = r_step_n;
        w_nbp_hit = 1'b0;
      end
    end else if (r_state == S_RUN) begin
      w_nstate = w_halt ? S_HALTED : S_RUN;
    end else if (w_halt) begin
      w_nstate = S_HALTED;
    end else if (w_resume) begin
      w_nstate = S_RUN;
    end else if (w_step) begin
      w_nstate = (r_step_n == '0) ? S_HALTED : S_STEP;
      w_nrem   = r_step_n;
    end else if (r_rem == STEP_W'(1)) begin
      w_nstate = S_HALTED;
    end else begin
      w_nrem = r_rem - STEP_W'(1);
    end
  end
  // run-control state with registered enable, status, ack and cycle counter
  always_ff @(posedge sysclk or posedge reset)
    if (reset) begin
      r_state       <= RST_STATE;
      r_rem         <= '0;
      r_bp_mask     <= 1'b0;
      r_bp_hit      <= 1'b0;
      r_dbg_clk_en  <= ~HALT_ON_RESET;
      r_halted      <= HALT_ON_RESET;
      r_ack         <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state       <= w_nstate;
      r_rem         <= w_nrem;
      r_bp_hit      <= w_nbp_hit;
      r_dbg_clk_en  <= (w_nstate != S_HALTED);
      r_halted      <= (w_nstate == S_HALTED);
      r_ack         <= r_ack ^ r_pend;
      r_cycle_count <= r_cycle_count + 32'(r_dbg_clk_en);
      r_bp_mask     <= (r_state == S_HALTED && w_nstate != S_HALTED) ? 1'b1 :
                       (r_dbg_clk_en ? 1'b0 : r_bp_mask);
    end
  assign cmd_ack_toggle = r_ack;
  assign dbg_clk_en     = r_dbg_clk_en;
  assign halted         = r_halted;
  assign bp_hit         = r_bp_hit;
  assign cycle_count    = r_cycle_count;
endmodule

// File: tb/tb_dbg_run_ctrl.sv
// tb_dbg_run_ctrl: directed checks of run control, stepping, breakpoints and counter wrap
module tb_dbg_run_ctrl;
  logic        sysclk;
  logic        reset;
  logic        cmd_toggle;
  logic [1:0]  cmd;
  logic [7:0]  step_count;
  logic        cmd_ack_toggle;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        dbg_clk_en;
  logic        halted;
  logic        bp_hit;
  logic [31:0] cycle_count;
  int          n_checks;
  int          n_fail;
  logic        exp_ack;
  dbg_run_ctrl dut (
    .sysclk(sysclk), .reset(reset), .cmd_toggle(cmd_toggle), .cmd(cmd),
    .step_count(step_count), .cmd_ack_toggle(cmd_ack_toggle), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .dbg_clk_en(dbg_clk_en), .halted(halted),
    .bp_hit(bp_hit), .cycle_count(cycle_count)
  );
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;
  task automatic send(input logic [1:0] c, input logic [7:0] n);
    @(negedge sysclk);
    cmd = c;
    step_count = n;
    cmd_toggle = ~cmd_toggle;
    exp_ack = ~exp_ack;
    repeat (4) @(posedge sysclk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    cmd_toggle = 1'b0; cmd = 2'b00; step_count = 8'd0;
    bp_en = 1'b0; bp_addr = 32'd0; pc = 32'd0; exp_ack = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    n_checks++;
    if ({dbg_clk_en, halted, bp_hit, cmd_ack_toggle} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 1000", {dbg_clk_en, halted, bp_hit, cmd_ack_toggle});
    end
    n_checks++;
    if (cycle_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_count: got %h expected 0", cycle_count);
    end
    @(negedge sysclk);
    reset = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    n_checks++;
    if (cycle_count !== 32'd3) begin
      n_fail++; $display("FAIL run_count: got %0d expected 3", cycle_count);
    end
  endtask
  task automatic test_run_ignores;
    send(2'b11, 8'd3);
    n_checks++;
    if (cmd_ack_toggle !== exp_ack) begin
      n_fail++; $display("FAIL run_step_ack: got %b expected %b", cmd_ack_toggle, exp_ack);
    end
    repeat (10) @(posedge sysclk);
    #1;
    n_checks++;
    if ({dbg_clk_en, halted} !== 2'b10) begin
      n_fail++; $display("FAIL run_step_ignored: got %b expected 10", {dbg_clk_en, halted});
    end
    send(2'b10, 8'd0);
    n_checks++;
    if ({cmd_ack_toggle, dbg_clk_en, halted} !== {exp_ack, 2'b10}) begin
      n_fail++; $display("FAIL run_resume_ignored: got %b expected %b", {cmd_ack_toggle, dbg_clk_en, halted}, {exp_ack, 2'b10});
    end
  endtask
  task automatic test_halt;
    int k;
    logic [31:0] c0;
    logic [31:0] c1;
    @(negedge sysclk);
    c0 = cycle_count;
    cmd = 2'b01;
    cmd_toggle = ~cmd_toggle;
    exp_ack = ~exp_ack;
    k = 0;
    while (k < 8 && (k == 0 || dbg_clk_en)) begin
      @(posedge sysclk);
      #1;
      k++;
    end
    n_checks++;
    if (k !== 4) begin
      n_fail++; $display("FAIL halt_latency: got %0d edges expected 4", k);
    end
    n_checks++;
    if ({dbg_clk_en, halted, cmd_ack_toggle} !== {2'b01, exp_ack}) begin
      n_fail++; $display("FAIL halt_state: got %b expected %b", {dbg_clk_en, halted, cmd_ack_toggle}, {2'b01, exp_ack});
    end
    n_checks++;
    if (cycle_count !== c0 + 32'd4) begin
      n_fail++; $display("FAIL halt_count: got %0d expected %0d", cycle_count, c0 + 32'd4);
    end
    c1 = cycle_count;
    repeat (5) @(posedge sysclk);
    #1;
    n_checks++;
    if (cycle_count !== c1) begin
      n_fail++; $display("FAIL halt_frozen: got %0d expected %0d", cycle_count, c1);
    end
  endtask
  task automatic test_step5;
    int k;
    logic [31:0] c0;
    c0 = cycle_count;
    send(2'b11, 8'd5);
    n_checks++;
    if ({dbg_clk_en, halted, cmd_ack_toggle} !== {2'b10, exp_ack}) begin
      n_fail++; $display("FAIL step_start: got %b expected %b", {dbg_clk_en, halted, cmd_ack_toggle}, {2'b10, exp_ack});
    end
    k = 0;
    while (k < 300 && (k == 0 || dbg_clk_en)) begin
      @(posedge sysclk);
      #1;
      k++;
    end
    n_checks++;
    if (k !== 5) begin
      n_fail++; $display("FAIL step_len: got %0d cycles expected 5", k);
    end
    n_checks++;
    if (cycle_count !== c0 + 32'd5) begin
      n_fail++; $display("FAIL step_count: got %0d expected %0d", cycle_count, c0 + 32'd5);
    end
    n_checks++;
    if ({halted, bp_hit} !== 2'b10) begin
      n_fail++; $display("FAIL step_end: got %b expected 10", {halted, bp_hit});
    end
  endtask
  task automatic test_breakpoint;
    int k;
    int halts;
    @(negedge sysclk);
    bp_en = 1'b1;
    bp_addr = 32'h0000001C;
    pc = 32'd0;
    send(2'b10, 8'd0);
    n_checks++;
    if ({dbg_clk_en, halted} !== 2'b10) begin
      n_fail++; $display("FAIL bp_resume: got %b expected 10", {dbg_clk_en, halted});
    end
    k = 0;
    while (k < 50) begin
      @(posedge sysclk);
      #1;
      k++;
      if (halted) break;
      pc = pc + 32'd4;
    end
    n_checks++;
    if (pc !== 32'h1C) begin
      n_fail++; $display("FAIL bp_halt_pc: got %h expected 0000001c", pc);
    end
    n_checks++;
    if ({dbg_clk_en, halted, bp_hit} !== 3'b011) begin
      n_fail++; $display("FAIL bp_halt_state: got %b expected 011", {dbg_clk_en, halted, bp_hit});
    end
    send(2'b10, 8'd0);
    n_checks++;
    if ({dbg_clk_en, halted, bp_hit} !== 3'b100) begin
      n_fail++; $display("FAIL bp_resume2: got %b expected 100", {dbg_clk_en, halted, bp_hit});
    end
    halts = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge sysclk);
      #1;
      if (halted) halts++;
      pc = pc + 32'd4;
    end
    n_checks++;
    if (halts !== 0 || bp_hit !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_retrigger: got halts=%0d bp_hit=%b expected 0 0", halts, bp_hit);
    end
    send(2'b01, 8'd0);
    bp_en = 1'b0;
    n_checks++;
    if ({halted, bp_hit} !== 2'b10) begin
      n_fail++; $display("FAIL bp_cmd_halt: got %b expected 10", {halted, bp_hit});
    end
  endtask
  task automatic test_step_zero_and_abort;
    int k;
    logic [31:0] c0;
    send(2'b11, 8'd0);
    repeat (3) @(posedge sysclk);
    #1;
    n_checks++;
    if ({cmd_ack_toggle, dbg_clk_en, halted} !== {exp_ack, 2'b01}) begin
      n_fail++; $display("FAIL step0: got %b expected %b", {cmd_ack_toggle, dbg_clk_en, halted}, {exp_ack, 2'b01});
    end
    c0 = cycle_count;
    send(2'b11, 8'd200);
    repeat (10) @(posedge sysclk);
    @(negedge sysclk);
    cmd = 2'b01;
    cmd_toggle = ~cmd_toggle;
    exp_ack = ~exp_ack;
    k = 0;
    while (k < 8 && (k == 0 || dbg_clk_en)) begin
      @(posedge sysclk);
      #1;
      k++;
    end
    n_checks++;
    if (k !== 4) begin
      n_fail++; $display("FAIL step_abort_latency: got %0d edges expected 4", k);
    end
    n_checks++;
    if (cycle_count !== c0 + 32'd14) begin
      n_fail++; $display("FAIL step_abort_count: got %0d expected %0d", cycle_count, c0 + 32'd14);
    end
    repeat (20) @(posedge sysclk);
    #1;
    n_checks++;
    if ({dbg_clk_en, halted, cmd_ack_toggle} !== {2'b01, exp_ack}) begin
      n_fail++; $display("FAIL step_abort_hold: got %b expected %b", {dbg_clk_en, halted, cmd_ack_toggle}, {2'b01, exp_ack});
    end
  endtask
  task automatic test_reset_mid_step;
    send(2'b11, 8'd50);
    repeat (5) @(posedge sysclk);
    @(negedge sysclk);
    cmd = 2'b01;
    cmd_toggle = ~cmd_toggle;
    repeat (2) @(posedge sysclk);
    #2;
    reset = 1'b1;
    cmd_toggle = 1'b0;
    exp_ack = 1'b0;
    #1;
    n_checks++;
    if ({dbg_clk_en, halted, bp_hit, cmd_ack_toggle} !== 4'b1000 || cycle_count !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: got %b cnt=%h expected 1000 cnt=0", {dbg_clk_en, halted, bp_hit, cmd_ack_toggle}, cycle_count);
    end
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    reset = 1'b0;
    repeat (6) @(posedge sysclk);
    #1;
    n_checks++;
    if ({dbg_clk_en, halted, cmd_ack_toggle} !== 3'b100) begin
      n_fail++; $display("FAIL pending_lost: got %b expected 100", {dbg_clk_en, halted, cmd_ack_toggle});
    end
    send(2'b01, 8'd0);
    n_checks++;
    if ({dbg_clk_en, halted, cmd_ack_toggle} !== 3'b011) begin
      n_fail++; $display("FAIL post_reset_cmd: got %b expected 011", {dbg_clk_en, halted, cmd_ack_toggle});
    end
  endtask
  task automatic test_wrap;
    send(2'b10, 8'd0);
    @(negedge sysclk);
    force dut.r_cycle_count = 32'hFFFFFFFE;
    #1;
    release dut.r_cycle_count;
    @(posedge sysclk);
    #1;
    n_checks++;
    if (cycle_count !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL wrap_0: got %h expected ffffffff", cycle_count);
    end
    @(posedge sysclk);
    #1;
    n_checks++;
    if (cycle_count !== 32'h00000000) begin
      n_fail++; $display("FAIL wrap_1: got %h expected 00000000", cycle_count);
    end
    @(posedge sysclk);
    #1;
    n_checks++;
    if (cycle_count !== 32'h00000001) begin
      n_fail++; $display("FAIL wrap_2: got %h expected 00000001", cycle_count);
    end
  endtask
  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_run_ignores();
    test_halt();
    test_step5();
    test_breakpoint();
    test_step_zero_and_abort();
    test_reset_mid_step();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dbg_run_ctrl.md
Name: dbg_run_ctrl

Overview:
- Run-control stage between jtag_test_logic and the RISC-V core clock.
- Accepts HALT / RESUME / STEP commands crossing from the tck domain through a toggle handshake. Compares core PC against a hardware breakpoint.
- Produces registered dbg_clk_en. An external glitch-free gate (BUFGCE-style) uses it to derive dbgclk from sysclk.
- Reports halted status, breakpoint hit and an enabled-cycle counter back to the JTAG data registers.

Parameters:
- SYNC_STAGES, 2, flops in the cmd_toggle synchronizer (min 2).
- STEP_W, 8, width of the step count.
- XLEN, 32, PC / breakpoint width.
- HALT_ON_RESET, 0, 1 means leave reset in HALTED, 0 means leave reset in RUN.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_toggle  in  1  tck-domain toggle; each transition is one new command.
- cmd  in  2  00 NOP, 01 HALT, 10 RESUME, 11 STEP; stable from toggle until ack.
- step_count  in  STEP_W  STEP length in cycles; stable with cmd.
- cmd_ack_toggle  out  1  toggles once per consumed command.
- bp_en  in  1  breakpoint enable; quasi-static.
- bp_addr  in  XLEN  breakpoint PC; quasi-static.
- pc  in  XLEN  core fetch PC (PCF, sysclk-aligned).
- dbg_clk_en  out  1  registered clock enable for dbgclk gate.
- halted  out  1  1 when in HALTED.
- bp_hit  out  1  sticky; breakpoint caused the last halt.
- cycle_count  out  32  count of sysclk cycles with dbg_clk_en=1.

Behaviour:

Reset values:
- dbg_clk_en = ~HALT_ON_RESET; halted = HALT_ON_RESET.
- bp_hit = 0, cmd_ack_toggle = 0, cycle_count = 0.
- Synchronizer chain and last-seen toggle = 0; step counter = 0.

CDC and command acceptance:
- cmd_toggle passes through SYNC_STAGES flops.
- A command is detected when the synchronized value differs from the last-seen value.
- On detect: cmd and step_count are captured in the same cycle; last-seen is updated; cmd_ack_toggle flips on the next edge.
- Effect is visible on dbg_clk_en at most SYNC_STAGES+2 sysclk edges after the cmd_toggle transition.
- Only one command may be outstanding; the tck side waits for the ack before toggling again.
- The tck side resets its toggle with trst/reset so both sides restart at 0. A 1 on cmd_toggle after reset is treated as a command.

State machine (RUN, HALTED, STEP). dbg_clk_en is registered from the next state: 1 in RUN/STEP, 0 in HALTED.
- RUN:
  - HALT goes to HALTED.
  - Breakpoint match goes to HALTED and sets bp_hit.
  - RESUME, STEP and NOP are acked, no effect.
- HALTED:
  - RESUME goes to RUN and clears bp_hit.
  - STEP with N>0 goes to STEP, loads remaining=N and clears bp_hit.
  - STEP with N=0 is acked and stays in HALTED.
  - HALT and NOP are acked, no effect.
- STEP:
  - dbg_clk_en is high for exactly N consecutive sysclk cycles, then HALTED. remaining decrements each enabled cycle; the exit happens when remaining==1.
  - HALT goes to HALTED immediately, discarding the remaining count.
  - RESUME goes to RUN.
  - A STEP received while in STEP reloads remaining with the new N; N=0 goes to HALTED.
  - A breakpoint match goes to HALTED and sets bp_hit.

Breakpoint:
- match = bp_en & (pc == bp_addr) & ~bp_mask, evaluated only in RUN/STEP.
- Halt is registered, so dbg_clk_en falls on the edge at which the match is sampled.
- bp_mask is set on every exit from HALTED and cleared after the first enabled cycle. This prevents re-triggering on the PC held at the breakpoint.
- bp_hit and an external HALT in the same cycle: go to HALTED with bp_hit=1.

cycle_count:
- Increments on each edge where dbg_clk_en=1.
- Wraps 0xFFFFFFFF to 0; no saturation.

Reset mid-operation:
- A reset during STEP or while a command is pending aborts to the reset state.
- The pending command is lost; no ack is issued.

Test Plan:
1. HALT_ON_RESET=0, release reset, then toggle with cmd=HALT -> dbg_clk_en falls within 4 edges; halted=1; cmd_ack_toggle=1; cycle_count frozen.
2. From HALTED, STEP with step_count=5 -> dbg_clk_en high exactly 5 cycles; cycle_count +5; halted=1; bp_hit=0.
3. bp_en=1, bp_addr=0x0000001C, RUN with pc incrementing by 4 from 0 -> halt when pc=0x1C; bp_hit=1. RESUME -> no immediate re-halt; pc advances past 0x1C; bp_hit=0.
4. STEP with N=0 from HALTED -> ack toggles; dbg_clk_en stays 0. Then STEP N=200 interrupted by HALT after ~10 cycles -> HALTED within 4 edges; remaining discarded.
5. Assert reset mid-STEP with N=50 -> all outputs return to reset values asynchronously. Later command toggles are accepted normally.
6. Preload cycle_count to 0xFFFFFFFE via forced RUN for 3 cycles -> counts 0xFFFFFFFF, 0x00000000, 0x00000001.
